// File: rtl/lcd_pkg.sv
// Shared LCD timing, colour widths and pixel types for the TFT colour stage.
// The sprite generator and its button front-end both import this package.
package lcd_pkg;

  localparam int H_START = 43;
  localparam int V_START = 12;
  localparam int H_ACT   = 480;
  localparam int V_ACT   = 272;

  localparam int R_W = 5;
  localparam int G_W = 6;
  localparam int B_W = 5;

  typedef struct packed {
    logic [R_W-1:0] r;
    logic [G_W-1:0] g;
    logic [B_W-1:0] b;
  } rgb565_t;

  typedef enum logic [1:0] {
    DIR_LEFT  = 2'd0,
    DIR_UP    = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  localparam rgb565_t RGB_WHITE = '{r: '1, g: '1, b: '1};

  // Each bit of the bar index switches one primary fully on: bit2 red, bit1 green, bit0 blue.
  function automatic rgb565_t bar_colour(input logic [2:0] bar);
    rgb565_t c;
    c.r = {R_W{bar[2]}};
    c.g = {G_W{bar[1]}};
    c.b = {B_W{bar[0]}};
    return c;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button front-end: 2-FF synchronizer, stable-time debouncer and a one-cycle
// pulse on each debounced rising edge.
module btn_debounce #(
  parameter int DB_CYCLES = 90000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic press_o
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  logic [1:0]    sync_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  // The counter measures how long the synchronized input has disagreed with the
  // accepted level; any agreeing sample restarts the measurement.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    if (sync_q[1] == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DB_CYCLES - 1)) begin
      cnt_d   = '0;
      level_d = sync_q[1];
      press_d = sync_q[1];
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/sprite_rgb_gen.sv
// Colour stage for the TFT controller: vertical colour bars with a white square
// sprite moved once per frame by four debounced push-buttons.
module sprite_rgb_gen #(
  parameter int H_START   = lcd_pkg::H_START,
  parameter int V_START   = lcd_pkg::V_START,
  parameter int H_ACT     = lcd_pkg::H_ACT,
  parameter int V_ACT     = lcd_pkg::V_ACT,
  parameter int BOX       = 32,
  parameter int STEP      = 4,
  parameter int DB_CYCLES = 90000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       DE,
  input  logic [9:0] HsyncCount,
  input  logic [8:0] VsyncCount,
  input  logic       Left,
  input  logic       Up,
  input  logic       Down,
  input  logic       Right,
  output logic [4:0] R,
  output logic [5:0] G,
  output logic [4:0] B,
  output logic       DE_d,
  output logic [8:0] pos_x,
  output logic [8:0] pos_y
);

  import lcd_pkg::*;

  localparam logic signed [9:0] X_MAX  = 10'(H_ACT - BOX);
  localparam logic signed [9:0] Y_MAX  = 10'(V_ACT - BOX);
  localparam logic signed [9:0] STEP_S = 10'(STEP);
  localparam logic [8:0]        X_RST  = 9'((H_ACT - BOX) / 2);
  localparam logic [8:0]        Y_RST  = 9'((V_ACT - BOX) / 2);

  logic [3:0] btnRaw;
  logic [3:0] press;
  assign btnRaw = {Right, Down, Up, Left};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk_i  (clk),
      .rst_i  (rst),
      .btn_i  (btnRaw[i]),
      .press_o(press[i])
    );
  end

  logic              frame_tick;
  logic [3:0]        pend_q, pend_d;
  logic [8:0]        pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic signed [9:0] dx, dy, xSum, ySum;
  logic [8:0]        xNext, yNext;

  assign frame_tick = (HsyncCount == 10'd0) && (VsyncCount == 9'd0);

  // Opposing requests cancel; a press landing on the tick itself survives the
  // clear so it is applied one frame later.
  always_comb begin
    dx = '0;
    dy = '0;
    if (pend_q[DIR_RIGHT] && !pend_q[DIR_LEFT]) dx = STEP_S;
    else if (pend_q[DIR_LEFT] && !pend_q[DIR_RIGHT]) dx = -STEP_S;
    if (pend_q[DIR_DOWN] && !pend_q[DIR_UP]) dy = STEP_S;
    else if (pend_q[DIR_UP] && !pend_q[DIR_DOWN]) dy = -STEP_S;

    xSum = $signed({1'b0, pos_x_q}) + dx;
    ySum = $signed({1'b0, pos_y_q}) + dy;

    if (xSum < 0)          xNext = '0;
    else if (xSum > X_MAX) xNext = X_MAX[8:0];
    else                   xNext = xSum[8:0];

    if (ySum < 0)          yNext = '0;
    else if (ySum > Y_MAX) yNext = Y_MAX[8:0];
    else                   yNext = ySum[8:0];

    pend_d  = frame_tick ? press : (pend_q | press);
    pos_x_d = frame_tick ? xNext : pos_x_q;
    pos_y_d = frame_tick ? yNext : pos_y_q;
  end

  logic [9:0] px;
  logic [8:0] py;
  logic       inBox;
  rgb565_t    rgb_d, rgb_q;
  logic       de_q;

  always_comb begin
    px    = HsyncCount - 10'(H_START);
    py    = VsyncCount - 9'(V_START);
    inBox = (px >= {1'b0, pos_x_q}) && (px < ({1'b0, pos_x_q} + 10'(BOX))) &&
            ({1'b0, py} >= {1'b0, pos_y_q}) && ({1'b0, py} < ({1'b0, pos_y_q} + 10'(BOX)));
    rgb_d = '0;
    if (DE) rgb_d = inBox ? RGB_WHITE : bar_colour(px[8:6]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q  <= '0;
      pos_x_q <= X_RST;
      pos_y_q <= Y_RST;
      rgb_q   <= '0;
      de_q    <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      rgb_q   <= rgb_d;
      de_q    <= DE;
    end
  end

  assign R     = rgb_q.r;
  assign G     = rgb_q.g;
  assign B     = rgb_q.b;
  assign DE_d  = de_q;
  assign pos_x = pos_x_q;
  assign pos_y = pos_y_q;

endmodule

// File: doc/sprite_rgb_gen.md
SPRITE_RGB_GEN -- requirements
Module: sprite_rgb_gen

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- H_START  43  HsyncCount value of first active pixel
- V_START  12  VsyncCount value of first active line
- H_ACT  480  active pixels per line
- V_ACT  272  active lines per frame
- BOX  32  sprite edge length, pixels
- STEP  4  pixels moved per accepted press
- DB_CYCLES  90000  debounce stable time, clk cycles

REQ-002 SHALL have ports, one per line: name  direction  width  meaning.
- clk  in  1  pixel clock (opclk domain)
- rst  in  1  reset; synchronous, active-high
- DE  in  1  active-area enable (hDE & vDE)
- HsyncCount  in  10  horizontal counter
- VsyncCount  in  9  vertical counter
- Left, Up, Down, Right  in  1 each  raw asynchronous buttons, active-high
- R  out  5  red
- G  out  6  green
- B  out  5  blue
- DE_d  out  1  DE delayed to align with R/G/B
- pos_x  out  9  sprite left edge, active-area pixels
- pos_y  out  9  sprite top edge, active-area lines

Function
REQ-003 SHALL pass each button through a 2-FF synchronizer, then a debouncer accepting a new level only after DB_CYCLES consecutive equal samples.
REQ-004 SHALL generate a one-cycle press pulse on each debounced 0->1 transition; no repeat while held.
REQ-005 SHALL hold one pending flag per direction, set by its press pulse, cleared only when applied.
REQ-006 SHALL assert frame_tick when HsyncCount==0 and VsyncCount==0; positions change only in that cycle.
REQ-007 On frame_tick SHALL apply pending flags: x -= STEP (Left), x += STEP (Right), y -= STEP (Up), y += STEP (Down), then clear those flags.
REQ-008 Left and Right pending together SHALL net to zero x change; both clear. Same for Up/Down.
REQ-009 Arithmetic SHALL saturate: x in [0, H_ACT-BOX], y in [0, V_ACT-BOX]; no wrap on under/overflow; computed in 10-bit signed-safe width.
REQ-010 A press pulse coincident with frame_tick SHALL stay pending and apply at the next frame_tick.
REQ-011 Pixel coordinates SHALL be px = HsyncCount-H_START, py = VsyncCount-V_START, used only while DE=1.
REQ-012 When DE=1 and pos_x<=px<pos_x+BOX and pos_y<=py<pos_y+BOX, colour SHALL be white (R=31, G=63, B=31).
REQ-013 Otherwise, when DE=1, colour SHALL be bar px[8:6] (0..7): bit2->R=31, bit1->G=63, bit0->B=31, else 0.
REQ-014 When DE=0, R, G, B SHALL be 0.
REQ-015 R, G, B and DE_d SHALL be registered: inputs at cycle n produce outputs at n+1 (latency 1).

Reset
REQ-016 With rst=1 at a clk edge: R=G=B=0, DE_d=0, pos_x=224, pos_y=120, pending flags=0, debounced levels=0, debounce counters=0, synchronizers=0.
REQ-017 Reset mid-frame or mid-debounce SHALL discard pending presses; operation resumes at the first frame_tick after release.

Structure
REQ-018 Shared package lcd_pkg SHALL hold timing constants (H_START, V_START, H_ACT, V_ACT), colour-width constants (5/6/5), and a packed rgb565 typedef.
REQ-019 Sub-module btn_debounce (synchronizer + debouncer + press pulse) SHALL be instantiated four times; all else in sprite_rgb_gen.
REQ-020 sprite_rgb_gen SHALL replace the disabled colour stage in TFTLCDctrl, fed by its DE/HsyncCount/VsyncCount on opclk.

Verification (DB_CYCLES=8 in bench)
REQ-021 Reset release, DE=1, HsyncCount=43+224, VsyncCount=12+120 -> next cycle R=31,G=63,B=31, DE_d=1.
REQ-022 DE=1, HsyncCount=43+10, VsyncCount=12+10 -> next cycle bar 0: R=0,G=0,B=0; HsyncCount=43+470 -> bar 7: R=31,G=63,B=31.
REQ-023 Right held 20 cycles, then frame_tick -> pos_x 224->228; held across 3 frames -> still 228 (no repeat).
REQ-024 Left glitch of 5 cycles -> no press, pos_x unchanged; Left and Right both pressed before one frame_tick -> pos_x unchanged, flags clear.
REQ-025 pos_y=236, Down pressed -> pos_y stays 240 after one frame, 240 after another; pos_x=2, Left -> 0.
REQ-026 Up pressed, rst asserted before frame_tick -> after release and frame_tick pos_y=120.
